// File: rtl/pb_press_ctrl.sv
// pb_press_ctrl: push-button gesture controller (sync, debounce, short/long/double press strobes)
// Ports:
//   clk          in  system clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   PB           in  raw button, asynchronous, 1 = released, 0 = pressed
//   held         out debounced level, high while a press is accepted
//   short_press  out one-cycle strobe, completed press shorter than LONG_CYCLES
//   long_press   out one-cycle strobe, press held LONG_CYCLES cycles (fires while held)
//   double_press out one-cycle strobe, two short presses within DBL_WINDOW
// Build option: define DOUBLE_PRESS_EN to enable double-press detection (WAIT2 state);
//   without it short_press fires at release debounce and double_press is tied 0.
module pb_press_ctrl #(
  parameter int DB_CYCLES   = 4,
  parameter int LONG_CYCLES = 20,
  parameter int DBL_WINDOW  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB,
  output logic held,
  output logic short_press,
  output logic long_press,
  output logic double_press
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  typedef enum logic [2:0] {
    IDLE, PRESS_DB, HELD, REL_DB
`ifdef DOUBLE_PRESS_EN
    , WAIT2
`endif
  } state_t;
  state_t state, state_n;
  logic pb_m, pb_s;
  logic [DW-1:0] db_cnt, db_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic long_fired, long_fired_n, short_n, long_n;
`ifdef DOUBLE_PRESS_EN
  localparam int WW = $clog2(DBL_WINDOW + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(DBL_WINDOW - 1);
  localparam logic [WW-1:0] WIN_MAX  = WW'(DBL_WINDOW);
  logic [WW-1:0] win_cnt, win_cnt_n;
  logic second, second_n, double_n;
`else
  localparam int unused_dbl_window = DBL_WINDOW;
  assign double_press = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {pb_m, pb_s} <= 2'b11;
    else {pb_m, pb_s} <= {PB, pb_m};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_fired  <= 1'b0;
      held        <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
`ifdef DOUBLE_PRESS_EN
      win_cnt      <= '0;
      second       <= 1'b0;
      double_press <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      db_cnt      <= db_cnt_n;
      hold_cnt    <= hold_cnt_n;
      long_fired  <= long_fired_n;
      held        <= state_n == HELD || state_n == REL_DB;
      short_press <= short_n;
      long_press  <= long_n;
`ifdef DOUBLE_PRESS_EN
      win_cnt      <= win_cnt_n;
      second       <= second_n;
      double_press <= double_n;
`endif
    end
  always_comb begin
    state_n      = state;
    db_cnt_n     = db_cnt;
    hold_cnt_n   = hold_cnt;
    long_fired_n = long_fired;
    short_n      = 1'b0;
    long_n       = 1'b0;
`ifdef DOUBLE_PRESS_EN
    win_cnt_n = win_cnt;
    second_n  = second;
    double_n  = 1'b0;
`endif
    case (state)
      IDLE:
        if (!pb_s) begin
          state_n  = PRESS_DB;
          db_cnt_n = '0;
        end
      PRESS_DB:
        if (pb_s)
`ifdef DOUBLE_PRESS_EN
          state_n = second ? WAIT2 : IDLE;
`else
          state_n = IDLE;
`endif
        else begin
          db_cnt_n = db_cnt + 1'b1;
          if (db_cnt == DB_LAST) begin
            state_n      = HELD;
            hold_cnt_n   = '0;
            long_fired_n = 1'b0;
          end
        end
      HELD: begin
        if (hold_cnt != HOLD_MAX) hold_cnt_n = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST && !long_fired) begin
          long_n       = 1'b1;
          long_fired_n = 1'b1;
`ifdef DOUBLE_PRESS_EN
          // a second press that turns long discards the pending short
          second_n = 1'b0;
`endif
        end
        if (pb_s) begin
          state_n  = REL_DB;
          db_cnt_n = '0;
        end
      end
      REL_DB:
        if (!pb_s) state_n = HELD;
        else begin
          db_cnt_n = db_cnt + 1'b1;
          if (db_cnt == DB_LAST) begin
            state_n = IDLE;
            if (!long_fired) begin
`ifdef DOUBLE_PRESS_EN
              double_n  = second;
              second_n  = !second;
              win_cnt_n = '0;
              state_n   = second ? IDLE : WAIT2;
`else
              short_n = 1'b1;
`endif
            end
          end
        end
`ifdef DOUBLE_PRESS_EN
      WAIT2: begin
        if (win_cnt != WIN_MAX) win_cnt_n = win_cnt + 1'b1;
        // a press on the expiry cycle wins over the pending short
        if (!pb_s) begin
          state_n  = PRESS_DB;
          db_cnt_n = '0;
        end else if (win_cnt >= WIN_LAST) begin
          short_n  = 1'b1;
          second_n = 1'b0;
          state_n  = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pb_press_ctrl.sv
// tb_pb_press_ctrl: self-checking bench for pb_press_ctrl (DB=4, LONG=20, WINDOW=10)
module tb_pb_press_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, PB = 1'b1;
  logic held, short_press, long_press, double_press;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct packed {byte k; int c;} ev_t;
  typedef struct {string name; string wave; string ev_imm; string ev_dbl;} vec_t;
  ev_t exp_q[$];
  byte tk[$];
  int tn[$];
  logic held_q = 1'b0;
  string cur = "reset";
  vec_t vecs[6];
  pb_press_ctrl dut (
    .clk(clk), .rst_n(rst_n), .PB(PB), .held(held),
    .short_press(short_press), .long_press(long_press), .double_press(double_press)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic got(input byte k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: event %c at cycle %0d, required no event", cur, k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.c != cyc) begin
        errors++;
        $display("FAIL %s: event %c at cycle %0d, required %c at cycle %0d", cur, k, cyc, e.k, e.c);
      end
    end
  endtask
  always @(negedge clk)
    if (!rst_n) held_q = 1'b0;
    else begin
      if (held && !held_q) got("H");
      if (!held && held_q) got("F");
      if (short_press) got("S");
      if (long_press) got("L");
      if (double_press) got("D");
      held_q = held;
    end
  task automatic tokenize(input string s);
    byte c;
    int last;
    tk.delete();
    tn.delete();
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (c >= "A" && c <= "Z") begin
        tk.push_back(c);
        tn.push_back(0);
      end else if (c >= "0" && c <= "9") begin
        last = tn.size() - 1;
        tn[last] = tn[last] * 10 + int'(c - "0");
      end
    end
  endtask
  task automatic check_zero(input string what);
    checks++;
    if ({held, short_press, long_press, double_press} != 4'b0) begin
      errors++;
      $display("FAIL %s: outputs %b, required 0000", what, {held, short_press, long_press, double_press});
    end
  endtask
  task automatic check_done();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events missing, first %c at cycle %0d", cur, exp_q.size(), exp_q[0].k, exp_q[0].c);
    end
    exp_q.delete();
  endtask
  task automatic expect_events(input string s, input int t0);
    tokenize(s);
    foreach (tk[i]) exp_q.push_back('{k: tk[i], c: t0 + tn[i]});
  endtask
  task automatic do_reset();
    PB = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    int t0;
    do_reset();
    cur = v.name;
    t0 = cyc;
`ifdef DOUBLE_PRESS_EN
    expect_events(v.ev_dbl, t0);
`else
    expect_events(v.ev_imm, t0);
`endif
    tokenize(v.wave);
    foreach (tk[i]) begin
      PB = (tk[i] == "L") ? 1'b0 : 1'b1;
      repeat (tn[i]) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check_done();
  endtask
  initial begin
    int t1;
    vecs[0] = '{"glitch_then_press", "L2 H10 L8 H30", "H19 F27 S27", "H19 F27 S37"};
    vecs[1] = '{"release_bounce", "L12 H1 L1 H1 L1 H30", "H7 F23 S23", "H7 F23 S33"};
    vecs[2] = '{"long_hold", "L40 H20", "H7 L27 F47", "H7 L27 F47"};
    vecs[3] = '{"two_press_gap5", "L8 H5 L8 H30", "H7 F15 S15 H20 F28 S28", "H7 F15 H20 F28 D28"};
    vecs[4] = '{"two_press_gap15", "L8 H15 L8 H30", "H7 F15 S15 H30 F38 S38", "H7 F15 S25 H30 F38 S48"};
    vecs[5] = '{"short_then_long", "L8 H5 L30 H20", "H7 F15 S15 H20 L40 F50", "H7 F15 H20 L40 F50"};
    foreach (vecs[i]) run_vec(vecs[i]);
    do_reset();
    cur = "reset_mid_held";
    expect_events("H7", cyc);
    PB = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("in_reset");
    end
    check_done();
    rst_n = 1'b1;
    t1 = cyc;
    expect_events("H7", t1);
    repeat (20) @(posedge clk);
    #1;
    check_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
